// File: rtl/counter_pkg.sv
// Shared types for the counter family: the arbiter FSM state and a binary-to-Gray helper.
package counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    // Widest count the Gray helper supports; callers zero-extend and truncate.
    localparam int unsigned GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/counter_gray_arb_rr_pick.sv
// Combinational round-robin selector: scans from last_owner+1 (mod NREQ), first set request wins.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_owner_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(last_owner_i) + k) % NREQ);
            if (!valid_o && req_i[cand]) begin
                valid_o  = 1'b1;
                idx_o    = cand;
                onehot_o = NREQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/counter_gray_arb.sv
// Round-robin arbitrated shared counter with Gray-coded output.
// Define COUNTER_GRAY_ARB_TIMEOUT_EN to bound ownership to MAX_HOLD cycles with a timeout pulse.
module counter_gray_arb
    import counter_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         inc,
    input  logic                    clr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    busy,
    output logic [WIDTH-1:0]        gray_count,
    output logic                    timeout
);

    localparam int unsigned IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || WIDTH > GRAY_MAX_W || MAX_HOLD < 1) begin : g_param_check
        $error("counter_gray_arb: illegal parameter combination");
    end

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     gnt_id_q, gnt_id_d;
    logic [IW-1:0]     last_owner_q, last_owner_d;
    logic [WIDTH-1:0]  count_q, count_d;

    logic [NREQ-1:0]   pick_onehot;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;

`ifdef COUNTER_GRAY_ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0]     hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .onehot_o     (pick_onehot),
        .idx_o        (pick_idx),
        .valid_o      (pick_valid)
    );

    // Next-state: arbitrate in IDLE, count and watch for release in OWN; clr wins over inc.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gnt_id_d     = gnt_id_q;
        last_owner_d = last_owner_q;
        count_d      = count_q;
`ifdef COUNTER_GRAY_ARB_TIMEOUT_EN
        hold_d       = hold_q;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = OWN;
                    gnt_d        = pick_onehot;
                    gnt_id_d     = pick_idx;
                    last_owner_d = pick_idx;
`ifdef COUNTER_GRAY_ARB_TIMEOUT_EN
                    hold_d       = '0;
`endif
                end
            end
            OWN: begin
                if (|(gnt_q & inc)) begin
                    count_d = count_q + WIDTH'(1);
                end
                if (!(|(gnt_q & req))) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                end
`ifdef COUNTER_GRAY_ARB_TIMEOUT_EN
                else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
`endif
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
        if (clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            gnt_id_q     <= '0;
            last_owner_q <= IW'(NREQ - 1);
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gnt_id_q     <= gnt_id_d;
            last_owner_q <= last_owner_d;
            count_q      <= count_d;
        end
    end

`ifdef COUNTER_GRAY_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt        = gnt_q;
    assign gnt_id     = gnt_id_q;
    assign busy       = (state_q == OWN);
    assign gray_count = WIDTH'(bin2gray(GRAY_MAX_W'(count_q)));

endmodule

// File: tb/tb_counter_gray_arb.sv
// Directed self-checking bench for counter_gray_arb (NREQ=4, WIDTH=8, MAX_HOLD=16).
module tb_counter_gray_arb;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned MAX_HOLD = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  inc;
    logic             clr;
    logic [NREQ-1:0]  gnt;
    logic [1:0]       gnt_id;
    logic             busy;
    logic [WIDTH-1:0] gray_count;
    logic             timeout;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    counter_gray_arb #(
        .NREQ     (NREQ),
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .inc        (inc),
        .clr        (clr),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .gray_count (gray_count),
        .timeout    (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] prev_gray;
        logic [NREQ-1:0]  exp_g;
        int               order [5];
        order = '{0, 1, 2, 3, 0};

        rst_n = 1'b0;
        req   = '0;
        inc   = '0;
        clr   = 1'b0;
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_gnt_id", 32'(gnt_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_gray", 32'(gray_count), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester: grant latency and five increments (bin 5 -> gray 7)
        req = 4'b0001;
        step();
        check("grant0_gnt", 32'(gnt), 32'h1);
        check("grant0_busy", 32'(busy), 32'h1);
        check("grant0_id", 32'(gnt_id), 32'h0);
        inc = 4'b0001;
        repeat (5) step();
        inc = 4'b0000;
        check("inc5_gray", 32'(gray_count), 32'h07);

        // Non-owner increment ignored, then clr beats a simultaneous owner increment
        inc = 4'b0100;
        step();
        inc = 4'b0000;
        check("nonowner_inc_gray", 32'(gray_count), 32'h07);
        clr = 1'b1;
        inc = 4'b0001;
        step();
        clr = 1'b0;
        inc = 4'b0000;
        check("clr_over_inc_gray", 32'(gray_count), 32'h00);

        // Wrap: 255 increments reach 0xFF (gray 0x80), one more wraps to 0
        inc = 4'b0001;
        repeat (255) step();
        check("preset_ff_gray", 32'(gray_count), 32'h80);
        prev_gray = gray_count;
        step();
        inc = 4'b0000;
        check("wrap_gray", 32'(gray_count), 32'h00);
        check("wrap_onebit", 32'($countones(prev_gray ^ gray_count)), 32'h1);

        req = 4'b0000;
        step();
        check("release_gnt", 32'(gnt), 32'h0);
        check("release_busy", 32'(busy), 32'h0);
        check("release_id", 32'(gnt_id), 32'h0);

        // Reset mid-ownership with increment active
        req = 4'b0001;
        step();
        check("pre_rst_gnt", 32'(gnt), 32'h1);
        inc = 4'b0001;
        step();
        step();
        check("pre_rst_gray", 32'(gray_count), 32'h03);
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(gnt), 32'h0);
        check("async_rst_gray", 32'(gray_count), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        req = 4'b0100;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_gnt", 32'(gnt), 32'h4);
        check("post_rst_id", 32'(gnt_id), 32'h2);
        check("post_rst_gray", 32'(gray_count), 32'h0);
        inc = 4'b0000;
        req = 4'b0000;
        step();

        // Round robin from reset, each owner drops after two cycles
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << order[k];
            step();
            check($sformatf("rr%0d_gnt", k), 32'(gnt), 32'(exp_g));
            check($sformatf("rr%0d_id", k), 32'(gnt_id), 32'(order[k]));
            step();
            check($sformatf("rr%0d_hold", k), 32'(gnt), 32'(exp_g));
            req[order[k]] = 1'b0;
            step();
            check($sformatf("rr%0d_idle_gnt", k), 32'(gnt), 32'h0);
            check($sformatf("rr%0d_idle_busy", k), 32'(busy), 32'h0);
            req = 4'b1111;
        end
        req = 4'b0000;
        step();

        // Long hold with two requesters
        do_reset();
        req = 4'b0011;
        step();
        check("hold_start_gnt", 32'(gnt), 32'h1);
        repeat (15) step();
        check("hold16_gnt", 32'(gnt), 32'h1);
        check("hold16_timeout", 32'(timeout), 32'h0);
        step();
`ifdef COUNTER_GRAY_ARB_TIMEOUT_EN
        check("to_gnt", 32'(gnt), 32'h0);
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_busy", 32'(busy), 32'h0);
        step();
        check("to_next_gnt", 32'(gnt), 32'h2);
        check("to_next_id", 32'(gnt_id), 32'h1);
        check("to_pulse_end", 32'(timeout), 32'h0);
`else
        check("nto_gnt", 32'(gnt), 32'h1);
        check("nto_timeout", 32'(timeout), 32'h0);
        step();
        check("nto_gnt2", 32'(gnt), 32'h1);
        check("nto_timeout2", 32'(timeout), 32'h0);
`endif
        req = 4'b0000;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_gray_arb.md
COUNTER_GRAY_ARB -- requirements
Module: counter_gray_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter WIDTH, default 8: width of the shared count.
REQ-003 Parameter MAX_HOLD, default 16: ownership cycle limit; used only by the timeout feature.
REQ-004 Port clk, input, 1: clock; all logic SHALL be rising-edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port req, input, NREQ: per-requester ownership request, level.
REQ-007 Port inc, input, NREQ: per-requester increment strobe.
REQ-008 Port clr, input, 1: synchronous clear of the shared count.
REQ-009 Port gnt, output, NREQ: registered one-hot grant.
REQ-010 Port gnt_id, output, $clog2(NREQ): binary index of the owner; 0 when idle.
REQ-011 Port busy, output, 1: high while in OWN.
REQ-012 Port gray_count, output, WIDTH: Gray code of the internal binary count.
REQ-013 Port timeout, output, 1: one-cycle forced-release pulse.

Function
REQ-014 FSM SHALL have exactly two states: IDLE and OWN.
REQ-015 IDLE -> OWN when any req bit is high at a clock edge; the selected gnt bit SHALL be high from that edge on (1-cycle latency).
REQ-016 Selection: round-robin; search starts at last_owner+1 modulo NREQ; first set req bit wins.
REQ-017 OWN -> IDLE when req[owner] is low at an edge; gnt SHALL be all-zero from that edge on.
REQ-018 At least one IDLE cycle between owners (no direct handoff), even if other requests are pending.
REQ-019 req bits of non-owners during OWN SHALL be ignored and SHALL not affect state.
REQ-020 Binary count +1 at an edge iff gnt[i] & inc[i] for the owner; inc from non-owners and inc in IDLE SHALL be ignored.
REQ-021 Count SHALL wrap modulo 2^WIDTH (all-ones -> zero).
REQ-022 clr SHALL zero the count at the next edge, overriding a simultaneous increment, in either state.
REQ-023 gray_count = bin ^ (bin >> 1), combinational from the count register; successive values SHALL differ in exactly one bit.
REQ-024 last_owner SHALL update on every IDLE -> OWN transition.
REQ-025 gnt_id SHALL be consistent with gnt every cycle.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, gnt 0, gnt_id 0, busy 0, count 0 (gray_count 0), timeout 0, hold counter 0, last_owner NREQ-1 (req[0] highest priority after reset).
REQ-027 Reset assertion mid-OWN SHALL abort ownership with no further increment; first arbitration SHALL occur at the first edge after release.

Configuration
REQ-028 Macro COUNTER_GRAY_ARB_TIMEOUT_EN defined: a hold counter SHALL count cycles in OWN; on the edge where the owner has held MAX_HOLD cycles, the FSM SHALL go to IDLE, gnt SHALL clear, and timeout SHALL pulse high for that one cycle.
REQ-029 After a forced release, the released requester SHALL be lowest priority at the next arbitration; if still requesting, it MAY be re-granted only when no other req is high.
REQ-030 Macro undefined: no hold counter is instantiated, timeout SHALL be tied 0, and ownership SHALL be unbounded.

Structure
REQ-031 Shared package counter_pkg SHALL hold the FSM state enum (IDLE, OWN) and a bin-to-Gray conversion function reused by counter modules.
REQ-032 One sub-module rr_pick (combinational round-robin selector: req, last_owner -> one-hot, index, valid); all registers stay in counter_gray_arb.

Verification
REQ-033 Reset, then req=0001 -> gnt=0001 after 1 edge, busy=1; inc[0] for 5 cycles -> gray_count=0x07 (bin 5).
REQ-034 req=1111 held, each owner drops req after 2 cycles -> grant order 0,1,2,3,0 with one IDLE cycle between each.
REQ-035 Count preset to 0xFF (WIDTH=8), owner inc -> bin 0x00, gray_count 0x80 -> 0x00, single-bit change.
REQ-036 Same edge with clr=1 and owner inc=1 -> count 0; inc[2] while gnt=0001 -> count unchanged.
REQ-037 TIMEOUT_EN, MAX_HOLD=16, req=0011 held -> owner 0 released after 16 OWN cycles, timeout pulse 1 cycle, owner 1 granted after 1 IDLE cycle.
REQ-038 rst_n low in OWN with inc active -> gnt=0 and count=0 immediately; release with req=0100 -> gnt=0100 after 1 edge.
